// File: rtl/btle_bit_serializer_pkg.sv
// Shared definitions for the BLE bit serializer: FSM encoding and whitening LFSR constants.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package btle_bit_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int LFSR_W = 7;

  // x^7 + x^4 + 1: the bit leaving position 6 re-enters at position 0
  // and is folded into position 4.
  localparam logic [LFSR_W-1:0] LFSR_TAP       = 7'b001_0000;
  localparam logic              LFSR_POS0_INIT = 1'b1;

  // Position 0 is forced to 1; positions 1..6 take the channel index MSB first.
  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [5:0] ch);
    return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], LFSR_POS0_INIT};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_W-1]} ^ (s[LFSR_W-1] ? LFSR_TAP : '0);
  endfunction

endpackage

// File: rtl/btle_bit_serializer_if.sv
// Byte-in / bit-out bundle between a packet source and the BLE bit serializer.
// Latency: n/a (wires only).
// Backpressure: byte_in_valid/byte_in_ready handshake; the bit side has no backpressure.
// master: packet source (drives bytes and channel, observes status).
// slave : serializer (consumes bytes, drives serial bits and status).
interface btle_bit_serializer_if;
  import btle_bit_serializer_pkg::*;

  logic [5:0] channel_number;
  logic [7:0] byte_in;
  logic       byte_in_valid;
  logic       byte_in_last;
  logic       byte_in_ready;
  logic       phy_bit;
  logic       bit_valid;
  logic       bit_valid_last;
  logic       busy;
  logic       underrun;

  modport master (
    output channel_number, byte_in, byte_in_valid, byte_in_last,
    input  byte_in_ready, phy_bit, bit_valid, bit_valid_last, busy, underrun
  );

  modport slave (
    input  channel_number, byte_in, byte_in_valid, byte_in_last,
    output byte_in_ready, phy_bit, bit_valid, bit_valid_last, busy, underrun
  );
endinterface

// File: rtl/btle_bit_serializer_lfsr.sv
// BLE data whitening sequence generator (7-bit LFSR, x^7+x^4+1).
// Latency: out_bit is combinational and already reflects this cycle's load/advance.
// Backpressure: none; the state only moves on load or advance.
// Ports: clk, rst (async active-low), load (seed from channel_number),
//        channel_number, advance (step once), out_bit (whitening bit).
module btle_whitening_lfsr
  import btle_bit_serializer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] channel_number,
  input  logic       advance,
  output logic       out_bit
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = lfsr_seed(channel_number);
    end else if (advance) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // The serializer registers phy_bit on the same edge the LFSR moves, so it
  // needs the post-update output bit.
  assign out_bit = lfsr_d[LFSR_W-1];

endmodule

// File: rtl/btle_bit_serializer.sv
// BLE packet byte stream to paced serial bit stream (LSB first), optional whitening (BTLE_WHITENING_EN).
// Latency: first bit_valid one cycle after the byte transfer; one bit every SAMPLE_PER_SYMBOL cycles.
// Backpressure: byte_in_ready high in IDLE and only in the last cycle of bit 7 of a non-last byte.
// Ports: clk, rst (async active-low), ser_if (slave side of btle_bit_serializer_if):
//        byte_in/_valid/_last/_ready, channel_number, phy_bit, bit_valid, bit_valid_last, busy, underrun.
module btle_bit_serializer
  import btle_bit_serializer_pkg::*;
#(
  parameter int SAMPLE_PER_SYMBOL = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  btle_bit_serializer_if.slave  ser_if
);

  localparam int              CW      = (SAMPLE_PER_SYMBOL > 2) ? $clog2(SAMPLE_PER_SYMBOL) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(SAMPLE_PER_SYMBOL - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          last_q, last_d;
  logic          ready_q, ready_d;
  logic          bv_q, bv_d;
  logic          bvl_q, bvl_d;
  logic          phy_q, phy_d;

  logic          xfer;
  logic          load_pkt;
  logic          lfsr_adv;
  logic          wh_bit;

  // ready_q is 0 in reset and for the first cycle after release, so no byte
  // can slip in before the block is running.
  assign xfer     = ser_if.byte_in_valid && ready_q;
  assign load_pkt = (state_q == ST_IDLE) && xfer;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    last_d  = last_q;
    bv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = 3'd0;
          byte_d  = ser_if.byte_in;
          last_d  = ser_if.byte_in_last;
          bv_d    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (bit_q != 3'd7) begin
            bit_d = bit_q + 3'd1;
            bv_d  = 1'b1;
          end else if (last_q) begin
            state_d = ST_IDLE;
          end else if (ser_if.byte_in_valid) begin
            // ready_q is high here, so this is a transfer: chain the next byte gaplessly.
            bit_d  = 3'd0;
            byte_d = ser_if.byte_in;
            last_d = ser_if.byte_in_last;
            bv_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;  // starved: underrun
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Whitening continues across bytes of one packet and is reseeded only at packet start.
  assign lfsr_adv = bv_d && (state_q == ST_SHIFT);

`ifdef BTLE_WHITENING_EN
  btle_whitening_lfsr u_lfsr (
    .clk            (clk),
    .rst            (rst),
    .load           (load_pkt),
    .channel_number (ser_if.channel_number),
    .advance        (lfsr_adv),
    .out_bit        (wh_bit)
  );
`else
  assign wh_bit = 1'b0;
`endif

  assign phy_d   = bv_d ? (byte_d[bit_d] ^ wh_bit) : phy_q;
  assign bvl_d   = bv_d && (bit_d == 3'd7) && last_d;
  assign ready_d = (state_d == ST_IDLE) ||
                   ((cnt_d == CNT_MAX) && (bit_d == 3'd7) && !last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 8'd0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      bv_q    <= 1'b0;
      bvl_q   <= 1'b0;
      phy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      bv_q    <= bv_d;
      bvl_q   <= bvl_d;
      phy_q   <= phy_d;
    end
  end

  assign ser_if.byte_in_ready  = ready_q;
  assign ser_if.bit_valid      = bv_q;
  assign ser_if.bit_valid_last = bvl_q;
  assign ser_if.phy_bit        = phy_q;
  assign ser_if.busy           = (state_q == ST_SHIFT);
  // Combinational so the pulse lands in the starved cycle itself; it lasts one
  // cycle because the FSM leaves SHIFT on the following edge.
  assign ser_if.underrun       = (state_q == ST_SHIFT) && ready_q && !ser_if.byte_in_valid;

endmodule

// File: doc/btle_bit_serializer.md
BTLE_BIT_SERIALIZER -- requirements
Module: btle_bit_serializer

Interface
REQ-001 The block SHALL have parameter SAMPLE_PER_SYMBOL, default 8: clock cycles per emitted bit (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-low reset (block in reset while rst=0).
REQ-004 The block SHALL have port channel_number, input, 6: BLE channel index (0..39), sampled at packet start.
REQ-005 The block SHALL have port byte_in, input, 8: payload byte, sent LSB first.
REQ-006 The block SHALL have port byte_in_valid, input, 1: byte_in is valid.
REQ-007 The block SHALL have port byte_in_last, input, 1: this byte is the last byte of the packet; qualified by byte_in_valid.
REQ-008 The block SHALL have port byte_in_ready, output, 1: the block accepts a byte this cycle.
REQ-009 The block SHALL have ports phy_bit (output, 1), bit_valid (output, 1), bit_valid_last (output, 1): serial bit stream feeding gfsk_modulation.
REQ-010 The block SHALL have ports busy (output, 1: packet in progress) and underrun (output, 1: one-cycle pulse on a starved packet).

Function
REQ-011 A byte SHALL transfer only on a cycle with byte_in_valid=1 and byte_in_ready=1.
REQ-012 The FSM SHALL have states IDLE and SHIFT; IDLE->SHIFT on transfer; SHIFT->IDLE after the last bit period of a last byte, or on underrun.
REQ-013 In IDLE, byte_in_ready SHALL be 1; in SHIFT, it SHALL be 1 only in the final cycle of bit 7's period (pace counter = SAMPLE_PER_SYMBOL-1) of a non-last byte.
REQ-014 The pace counter SHALL run 0..SAMPLE_PER_SYMBOL-1 and wrap; bit_valid SHALL be a one-cycle pulse when the counter = 0 in SHIFT.
REQ-015 The first bit_valid SHALL occur on the cycle after the transfer (latency 1); later bits SHALL follow every SAMPLE_PER_SYMBOL cycles.
REQ-016 Back-to-back bytes SHALL be gapless: bit 0 of the next byte SHALL follow bit 7 of the previous byte exactly SAMPLE_PER_SYMBOL cycles later.
REQ-017 phy_bit SHALL hold its value for the whole bit period and SHALL change only with bit_valid.
REQ-018 bit_valid_last SHALL equal bit_valid gated by (bit 7 AND the current byte is last).
REQ-019 If byte_in_valid=0 while byte_in_ready=1 in SHIFT, the block SHALL pulse underrun for one cycle, return to IDLE, and SHALL NOT emit bit_valid_last.
REQ-020 busy SHALL be 1 in SHIFT and 0 in IDLE.
REQ-021 When not in SHIFT, bit_valid and bit_valid_last SHALL be 0 and phy_bit SHALL hold its last value.

Reset
REQ-022 On rst=0, all outputs SHALL go to 0 except byte_in_ready, which SHALL be 1 one cycle after release; FSM SHALL be in IDLE, counters SHALL be 0, and the LFSR SHALL be 7'b0.
REQ-023 On reset mid-packet, the packet SHALL be dropped silently, with no underrun and no bit_valid_last.

Configuration
REQ-024 Macro BTLE_WHITENING_EN defined: each output bit SHALL be data XOR lfsr[6] of a 7-bit x^7+x^4+1 LFSR. On packet start, the LFSR SHALL load pos0=1 and pos1..6=channel_number[5:0], MSB at pos1. The LFSR SHALL advance once per bit_valid.
REQ-025 Macro BTLE_WHITENING_EN undefined: phy_bit SHALL be the raw data bit, the LFSR logic SHALL be absent, and channel_number SHALL stay present and be ignored.

Structure
REQ-026 FSM state encoding, the LFSR width (7), and the LFSR init/tap constants SHALL reside in the shared btle package/config header.
REQ-027 Whitening SHALL be a sub-module btle_whitening_lfsr with ports load, channel_number, advance, and out_bit.

Verification
REQ-028 SPS=8, single byte 0xA5 last, whitening off -> bits 1,0,1,0,0,1,0,1 at cycles T+1, T+9, ..., T+57; bit_valid_last at T+57; busy falls at T+65.
REQ-029 Two bytes 0xFF then 0x00 (last), valid held -> 16 bits evenly spaced by 8 cycles with no gap; byte_in_ready high only at T+64 in SHIFT.
REQ-030 Whitening on, channel 37, byte 0x00 -> bits 1,0,1,1,0,0,0,1.
REQ-031 Non-last byte, byte_in_valid dropped before its bit 7 ends -> underrun pulse at T+64, busy=0 next cycle, no bit_valid_last.
REQ-032 rst=0 asserted mid-byte (cycle T+20) -> outputs 0 immediately; after release, a new byte restarts cleanly with latency 1.
REQ-033 SPS=2 sweep with random byte lengths 1..37 -> bit count = 8 x bytes, exactly one bit_valid_last per packet.
